// File: rtl/add_arbiter_pkg.sv
// Shared miniRV common defines used by the adder arbiter.
//   DATA_W              : datapath width of the core (32).
//   ID_PC4/ID_BRT/ID_ALU: requester indices for PC+4, branch target and ALU add.
//   state_t             : result register occupancy (EMPTY/FULL).
package add_arbiter_pkg;

   localparam int unsigned DATA_W = 32;

   localparam int unsigned ID_PC4 = 0;
   localparam int unsigned ID_BRT = 1;
   localparam int unsigned ID_ALU = 2;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

endpackage

// File: rtl/alu_add.sv
// Plain WIDTH-bit adder; carry out is discarded (result is modulo 2^WIDTH).
//   a_i, b_i : operands
//   c_o      : a_i + b_i
module alu_add #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] c_o
);

   assign c_o = a_i + b_i;

endmodule

// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one adder between NREQ requesters. The granted
// requester's operands are summed and registered together with its index,
// then returned over a valid/ready response channel. The result register may
// be refilled in the same cycle it drains (one addition per cycle).
//   clk_i, rst_i : clock, synchronous active-high reset
//   req_valid_i  : per-requester valid
//   req_a_i/b_i  : packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready_o  : one-hot (or zero) acceptance
//   rsp_valid_o  : result register holds an unread sum
//   rsp_c_o      : registered sum
//   rsp_id_o     : index of the requester owning rsp_c_o
//   rsp_ready_i  : consumer takes the result this cycle
module add_arbiter
   import add_arbiter_pkg::*;
#(
   parameter int unsigned NREQ  = 2,
   parameter int unsigned WIDTH = DATA_W,
   parameter int unsigned IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [NREQ-1:0]       req_valid_i,
   input  logic [NREQ*WIDTH-1:0] req_a_i,
   input  logic [NREQ*WIDTH-1:0] req_b_i,
   output logic [NREQ-1:0]       req_ready_o,
   output logic                  rsp_valid_o,
   output logic [WIDTH-1:0]      rsp_c_o,
   output logic [IDW-1:0]        rsp_id_o,
   input  logic                  rsp_ready_i
);

   state_t           state;
   logic [IDW-1:0]   rr_ptr;
   logic [NREQ-1:0]  rot;
   logic [NREQ-1:0]  grant;
   logic [IDW-1:0]   grant_idx;
   logic [IDW-1:0]   next_ptr;
   logic             found;
   int unsigned      off;
   int unsigned      pos;
   logic [WIDTH-1:0] mux_a;
   logic [WIDTH-1:0] mux_b;
   logic [WIDTH-1:0] sum;
   logic             can_accept;
   logic             accept;

   // Rotate the valid vector so rr_ptr sits at bit 0; the first set bit is
   // then the distance from rr_ptr to the winner, and adding it back (with
   // wrap) gives the absolute index.
   always_comb begin
      rot   = NREQ'({req_valid_i, req_valid_i} >> rr_ptr);
      found = 1'b0;
      off   = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            off   = k;
         end
      end
      pos = 32'(rr_ptr) + off;
      if (pos >= NREQ) begin
         pos = pos - NREQ;
      end
      grant_idx = IDW'(pos);
      grant     = found ? (NREQ'(1) << grant_idx) : '0;
   end

   // AND-OR operand mux driven by the one-hot grant.
   always_comb begin
      mux_a = '0;
      mux_b = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         mux_a = mux_a | ({WIDTH{grant[i]}} & req_a_i[i*WIDTH +: WIDTH]);
         mux_b = mux_b | ({WIDTH{grant[i]}} & req_b_i[i*WIDTH +: WIDTH]);
      end
   end

   alu_add #(
      .WIDTH(WIDTH)
   ) u_add (
      .a_i(mux_a),
      .b_i(mux_b),
      .c_o(sum)
   );

   assign can_accept  = (state == ST_EMPTY) || rsp_ready_i;
   assign req_ready_o = (rst_i || !can_accept) ? '0 : grant;
   assign accept      = |req_ready_o;
   assign next_ptr    = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
   assign rsp_valid_o = (state == ST_FULL);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= ST_EMPTY;
         rsp_c_o  <= '0;
         rsp_id_o <= '0;
         rr_ptr   <= '0;
      end else if (accept) begin
         state    <= ST_FULL;
         rsp_c_o  <= sum;
         rsp_id_o <= grant_idx;
         rr_ptr   <= next_ptr;
      end else if ((state == ST_FULL) && rsp_ready_i) begin
         state <= ST_EMPTY;
      end
   end

endmodule

// File: tb/tb_add_arbiter.sv
module tb_add_arbiter;
   import add_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // NREQ=2 instance
   logic [1:0]  v2, ready2;
   logic [63:0] a2, b2;
   logic        rv2, rr2, id2;
   logic [31:0] c2;

   // NREQ=3 instance
   logic [2:0]  v3, ready3;
   logic [95:0] a3, b3;
   logic        rv3, rr3;
   logic [1:0]  id3;
   logic [31:0] c3;

   typedef struct packed {
      logic [1:0]  id;
      logic [31:0] c;
   } rsp_t;

   rsp_t q2[$];
   rsp_t q3[$];
   rsp_t e2, e3;
   int   total = 0;
   int   bad   = 0;

   add_arbiter #(.NREQ(2), .WIDTH(32)) u2 (
      .clk_i(clk), .rst_i(rst), .req_valid_i(v2), .req_a_i(a2), .req_b_i(b2),
      .req_ready_o(ready2), .rsp_valid_o(rv2), .rsp_c_o(c2), .rsp_id_o(id2),
      .rsp_ready_i(rr2)
   );

   add_arbiter #(.NREQ(3), .WIDTH(32)) u3 (
      .clk_i(clk), .rst_i(rst), .req_valid_i(v3), .req_a_i(a3), .req_b_i(b3),
      .req_ready_o(ready3), .rsp_valid_o(rv3), .rsp_c_o(c3), .rsp_id_o(id3),
      .rsp_ready_i(rr3)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitors: every handshake on the response channel pops the scoreboard.
   always @(negedge clk) begin
      if (!rst && rv2 && rr2) begin
         if (q2.size() == 0) begin
            total++;
            bad++;
            $display("FAIL mon2_unexpected: got id=%0d c=%h expected no response", id2, c2);
         end else begin
            e2 = q2.pop_front();
            chk("mon2_id", 32'(id2), 32'(e2.id));
            chk("mon2_c", c2, e2.c);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && rv3 && rr3) begin
         if (q3.size() == 0) begin
            total++;
            bad++;
            $display("FAIL mon3_unexpected: got id=%0d c=%h expected no response", id3, c3);
         end else begin
            e3 = q3.pop_front();
            chk("mon3_id", 32'(id3), 32'(e3.id));
            chk("mon3_c", c3, e3.c);
         end
      end
   end

   // One cycle on the 2-requester instance with a hand-computed expectation.
   task automatic step2(input logic [1:0] v, input logic rr,
                        input logic [31:0] x0, input logic [31:0] y0,
                        input logic [31:0] x1, input logic [31:0] y1,
                        input logic [1:0] er, input int unsigned eid,
                        input logic [31:0] ec);
      v2  = v;
      rr2 = rr;
      a2  = {x1, x0};
      b2  = {y1, y0};
      @(negedge clk);
      chk("ready2", 32'(ready2), 32'(er));
      if (er != 2'b00) q2.push_back(rsp_t'{id: 2'(eid), c: ec});
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      v2 = 2'b11; rr2 = 1'b1; a2 = '0; b2 = '0;
      v3 = '0;    rr3 = 1'b1; a3 = '0; b3 = '0;
      @(negedge clk);
      chk("rst_ready2", 32'(ready2), 32'd0);
      chk("rst_valid2", 32'(rv2), 32'd0);
      chk("rst_c2", c2, 32'd0);
      chk("rst_id2", 32'(id2), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      v2  = 2'b00;

      // Single request: 5+7
      step2(2'b01, 1'b1, 32'd5, 32'd7, 32'd0, 32'd0, 2'b01, ID_PC4, 32'd12);
      chk("lat_valid", 32'(rv2), 32'd1);
      step2(2'b00, 1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 0, 32'd0);
      chk("drained_valid", 32'(rv2), 32'd0);

      // Wrap-around arithmetic (pointer sits at 1, requester 0 found by wrap)
      step2(2'b01, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 2'b01, ID_PC4, 32'h0);
      step2(2'b10, 1'b1, 32'd0, 32'd0, 32'h8000_0000, 32'h8000_0000, 2'b10, ID_BRT, 32'h0);

      // Continuous contention: 0,1,0,1
      step2(2'b11, 1'b1, 32'd10, 32'd20, 32'd100, 32'd200, 2'b01, ID_PC4, 32'd30);
      step2(2'b11, 1'b1, 32'd10, 32'd20, 32'd100, 32'd200, 2'b10, ID_BRT, 32'd300);
      step2(2'b11, 1'b1, 32'd10, 32'd20, 32'd100, 32'd200, 2'b01, ID_PC4, 32'd30);
      step2(2'b11, 1'b1, 32'd10, 32'd20, 32'd100, 32'd200, 2'b10, ID_BRT, 32'd300);

      // Requester 0 alone, then contention must favour requester 1
      step2(2'b01, 1'b1, 32'd1, 32'd2, 32'd0, 32'd0, 2'b01, ID_PC4, 32'd3);
      step2(2'b11, 1'b1, 32'd10, 32'd20, 32'd100, 32'd200, 2'b10, ID_BRT, 32'd300);

      // Back-pressure for 3 cycles while FULL with both valid
      chk("bp_hold_c", c2, 32'd300);
      for (int i = 0; i < 3; i++) begin
         step2(2'b11, 1'b0, 32'd10, 32'd20, 32'd100, 32'd200, 2'b00, 0, 32'd0);
         chk("bp_hold_c", c2, 32'd300);
         chk("bp_hold_valid", 32'(rv2), 32'd1);
      end
      // Drain and accept in the same edge
      step2(2'b11, 1'b1, 32'd10, 32'd20, 32'd100, 32'd200, 2'b01, ID_PC4, 32'd30);
      chk("drain_accept_valid", 32'(rv2), 32'd1);
      chk("drain_accept_c", c2, 32'd30);

      // Reset while FULL and stalled: pending result is discarded
      step2(2'b00, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 0, 32'd0);
      rst = 1'b1;
      v2  = 2'b11;
      @(negedge clk);
      chk("midrst_ready2", 32'(ready2), 32'd0);
      @(posedge clk);
      #1;
      q2.delete();
      rst = 1'b0;
      chk("midrst_valid", 32'(rv2), 32'd0);
      chk("midrst_c", c2, 32'd0);
      chk("midrst_id", 32'(id2), 32'd0);
      step2(2'b11, 1'b1, 32'd10, 32'd20, 32'd100, 32'd200, 2'b01, ID_PC4, 32'd30);
      step2(2'b00, 1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 0, 32'd0);
      chk("final_valid2", 32'(rv2), 32'd0);

      // NREQ=3: continuous contention, order 0,1,2,0,1,2
      v3 = 3'b111;
      a3 = {32'd3, 32'h7FFF_FFFF, 32'hFFFF_FFF0};
      b3 = {32'd4, 32'd1,         32'h0000_0020};
      for (int k = 0; k < 6; k++) begin
         logic [2:0]  er3;
         logic [31:0] ec3;
         int unsigned ei3;
         case (k % 3)
            0:       begin er3 = 3'b001; ei3 = ID_PC4; ec3 = 32'h0000_0010; end
            1:       begin er3 = 3'b010; ei3 = ID_BRT; ec3 = 32'h8000_0000; end
            default: begin er3 = 3'b100; ei3 = ID_ALU; ec3 = 32'h0000_0007; end
         endcase
         @(negedge clk);
         chk("ready3", 32'(ready3), 32'(er3));
         if (er3 != 3'b000) q3.push_back(rsp_t'{id: 2'(ei3), c: ec3});
         @(posedge clk);
         #1;
      end
      v3 = '0;
      @(negedge clk);
      chk("idle_ready3", 32'(ready3), 32'd0);
      @(posedge clk);
      #1;
      chk("idle_valid3", 32'(rv3), 32'd0);
      chk("q2_empty", 32'(q2.size()), 32'd0);
      chk("q3_empty", 32'(q3.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/add_arbiter.md
# add_arbiter

Shares one 32-bit adder datapath between several requesters inside the miniRV-1 core, for example the PC+4 path, branch-target calculation and the ALU add path. Each cycle it grants at most one valid requester with a round-robin policy and drives that requester's operands into a single adder. It registers the sum together with the requester ID and returns it over a valid/ready response channel. The output register can be refilled in the same cycle it drains, so sustained throughput is one addition per cycle.

## Interface
- NREQ, 2: number of requesters (2..8).
- WIDTH, 32: operand and result width.
- IDW, $clog2(NREQ) (minimum 1): width of the requester ID.
- clk_i  in  1  clock; all logic is rising-edge.
- rst_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  NREQ  bit i set means requester i presents operands.
- req_a_i  in  NREQ*WIDTH  operand A; requester i occupies slice [i*WIDTH +: WIDTH].
- req_b_i  in  NREQ*WIDTH  operand B, same slicing as req_a_i.
- req_ready_o  out  NREQ  one-hot or zero; bit i set means requester i is accepted this cycle.
- rsp_valid_o  out  1  result register holds an unread sum.
- rsp_c_o  out  WIDTH  sum of the accepted operands, modulo 2^WIDTH.
- rsp_id_o  out  IDW  index of the requester that owns rsp_c_o.
- rsp_ready_i  in  1  consumer takes the result this cycle.

## Operation
- Output register states:
  - EMPTY (rsp_valid_o=0).
  - FULL (rsp_valid_o=1).
- can_accept = EMPTY, or (FULL and rsp_ready_i).
- Grant:
  - Combinational.
  - Picks the first i with req_valid_i[i]=1, searching upward from rr_ptr and wrapping past NREQ-1 to 0.
- Readiness: req_ready_o[i] = grant[i] and can_accept. It depends combinationally on req_valid_i and rsp_ready_i, but never on other outputs, so no combinational loop exists.
- Accept, i.e. any req_ready_o bit is set:
  - rsp_c_o <= a+b of the granted requester.
  - rsp_id_o <= granted index.
  - State goes to FULL.
  - rr_ptr <= (granted index + 1) mod NREQ.
- Drain without accept, i.e. FULL and rsp_ready_i and no valid requester: state goes to EMPTY. rsp_c_o and rsp_id_o keep their old values.
- FULL and rsp_ready_i=0:
  - All req_ready_o bits are 0.
  - Registers hold.
  - rr_ptr holds.
- rr_ptr changes only on accept. Idle cycles do not rotate priority.
- Arithmetic: WIDTH-bit add with carry discarded; 0xFFFFFFFF+1 gives 0x00000000. No flags are produced.
- Requester rules:
  - Keep valid and operands stable until ready.
  - Dropping valid before ready is allowed; the request is simply not taken.
- Reset:
  - rsp_valid_o=0, rsp_c_o=0, rsp_id_o=0, rr_ptr=0.
  - req_ready_o=0 while rst_i=1.
  - Reset asserted while FULL discards the pending result. No response for it appears after reset.

## Timing
- Latency: a request accepted in cycle N has its result visible in cycle N+1.
- Throughput: one accept per cycle while rsp_ready_i=1.
- Back-to-back from the same requester: allowed only when no other requester is valid. Otherwise the round-robin pointer forces alternation.
- Simultaneous drain and accept: the new sum replaces the old one in the same edge, and rsp_valid_o stays 1.
- Fairness: with all NREQ requesters continuously valid and rsp_ready_i=1, each is served exactly once every NREQ cycles.
- Reset is sampled on the edge. The first possible accept is the cycle after rst_i deasserts.

## Structure
- Instantiate the existing alu_add module once as the shared adder. Its a_i/b_i inputs come from the grant mux and its c_o drives the result register.
- Keep the round-robin grant logic inline; no separate arbiter sub-module.
- The shared package (miniRV common defines) holds:
  - the data width constant (32);
  - the requester-index constants: ID_PC4=0, ID_BRT=1, ID_ALU=2.
- Grant mux: an AND-OR mux indexed by the one-hot grant, so there is no priority chain beyond the round-robin search.

## Test plan
- Single request after reset: req_valid_i=01, a=5, b=7, rsp_ready_i=1. Required: req_ready_o=01 in cycle N; in cycle N+1 rsp_valid_o=1, rsp_c_o=12, rsp_id_o=0.
- Wrap-around: a=0xFFFFFFFF, b=1. Required: rsp_c_o=0x00000000. Also a=0x80000000, b=0x80000000 gives 0.
- Round-robin: both requesters valid continuously, rsp_ready_i=1. Required: rsp_id_o sequence 0,1,0,1. After requester 0 alone is served once, a following two-way contention grants 1 first.
- Back-pressure: rsp_ready_i=0 for 3 cycles while FULL with both requesters valid. Required: req_ready_o=00 and rsp_c_o stable for those 3 cycles. When rsp_ready_i rises, drain and accept happen in the same cycle and rsp_valid_o stays 1.
- Reset mid-operation: rst_i=1 while FULL with rsp_ready_i=0. Required next cycle: rsp_valid_o=0, rsp_c_o=0, rsp_id_o=0. The next contention grants requester 0.
- NREQ=3 instance, continuous contention. Required: grant order 0,1,2,0,1,2. Results match a reference model of every accepted a+b mod 2^32.
